prime_round_ctrl: RTL

PRIME_ROUND_CTRL -- requirements
Module: prime_round_ctrl

---
 rtl/prime_round_ctrl_pkg.sv | 18 +
 rtl/round_timer.sv | 28 ++
 rtl/prime_round_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/prime_round_ctrl_pkg.sv
// Shared types and constants for the prime-guessing round controller.
// Imported by the controller and by its countdown timer.
package prime_round_ctrl_pkg;

    localparam int TIMER_W = 16;
    localparam int SCORE_W = 7;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd127;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WAIT,
        PLAY,
        RESULT,
        OVER
    } state_t;

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter used as the PLAY-phase guess window.
// It stops at zero and raises a flag there.
module round_timer
    import prime_round_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/prime_round_ctrl.sv
// Round controller for the prime-guessing game. Each output is a flop.
// Flags are loaded from the next state, so they line up with the state they describe.
module prime_round_ctrl
    import prime_round_ctrl_pkg::*;
#(
    parameter int unsigned        GEN_LATENCY  = 4,
    parameter logic [TIMER_W-1:0] ROUND_CYCLES = 16'd50000,
    parameter int unsigned        LIVES        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               guess_valid,
    input  logic [SCORE_W-1:0] guess,
    input  logic [SCORE_W-1:0] gen_prime,
    output logic               gen_enable,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] target,
    output logic               round_active,
    output logic               hit,
    output logic               miss,
    output logic               game_over
);

    localparam logic [7:0] WAIT_LAST = 8'(GEN_LATENCY - 1);

    state_t     state, state_n;
    logic [7:0] wait_cnt;
    logic       timer_zero;
    logic       result_hit;
    logic       game_start;
    logic       round_end;
    logic       timer_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        result_hit = 1'b0;
        case (state)
            IDLE, OVER: if (start) state_n = GEN;
            GEN:        state_n = WAIT;
            WAIT:       if (wait_cnt == WAIT_LAST) state_n = PLAY;
            PLAY: begin
                // A guess on the expiry cycle wins over the timeout.
                if (guess_valid) begin
                    state_n    = RESULT;
                    result_hit = (guess == target);
                end else if (timer_zero) begin
                    state_n = RESULT;
                end
            end
            RESULT:     state_n = (lives == 2'd0) ? OVER : GEN;
            default:    state_n = IDLE;
        endcase
    end

    assign game_start = ((state == IDLE) || (state == OVER)) && start;
    assign round_end  = (state == PLAY) && (state_n == RESULT);
    assign timer_load = (state == WAIT) && (state_n == PLAY);

    round_timer u_round_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .dec        (state == PLAY),
        .load_value (ROUND_CYCLES - TIMER_W'(1)),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= 8'd0;
            gen_enable   <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            score        <= '0;
            lives        <= 2'd0;
            target       <= '0;
        end else begin
            wait_cnt     <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            gen_enable   <= (state_n == GEN);
            round_active <= (state_n == PLAY);
            game_over    <= (state_n == OVER);
            hit          <= round_end && result_hit;
            miss         <= round_end && !result_hit;
            if (game_start) begin
                score  <= '0;
                lives  <= 2'(LIVES);
                target <= '0;
            end
            if (timer_load) begin
                target <= gen_prime;
            end
            if (round_end && result_hit && (score != SCORE_MAX)) begin
                score <= score + SCORE_W'(1);
            end
            if (round_end && !result_hit && (lives != 2'd0)) begin
                lives <= lives - 2'd1;
            end
        end
    end

endmodule
